// File: rtl/if_inst_queue_if.sv
// if_inst_queue_if: fetch-to-ID queue handshake bundle (enqueue, dequeue, flush, status)
interface if_inst_queue_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);
  logic          flush;
  logic          enq_valid;
  logic          enq_ready;
  logic [31:0]   enq_pc;
  logic [31:0]   enq_instr;
  logic [18:0]   enq_except;
  logic          almost_full;
  logic          deq_valid;
  logic          deq_ready;
  logic [31:0]   deq_pc;
  logic [31:0]   deq_instr;
  logic [18:0]   deq_except;
  logic [AW:0]   count;
  modport master (
    output flush, enq_valid, enq_pc, enq_instr, enq_except, deq_ready,
    input  enq_ready, almost_full, deq_valid, deq_pc, deq_instr, deq_except, count
  );
  modport slave (
    input  flush, enq_valid, enq_pc, enq_instr, enq_except, deq_ready,
    output enq_ready, almost_full, deq_valid, deq_pc, deq_instr, deq_except, count
  );
endinterface

// File: rtl/if_inst_queue.sv
// if_inst_queue: circular instruction fetch queue between fetch and ID, flushable
module if_inst_queue #(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input logic            clk,
  input logic            rst,
  if_inst_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 32 + 32 + 19;
  localparam logic [PW-1:0] AF = PW'(AF_LEVEL);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, occ;
  logic [EW-1:0] head;
  logic          empty, full, enq_fire, deq_fire;

  always_comb begin
    empty    = rd_ptr == wr_ptr;
    full     = rd_ptr[AW-1:0] == wr_ptr[AW-1:0] && rd_ptr[AW] != wr_ptr[AW];
    enq_fire = q.enq_valid && !full && !q.flush;
    deq_fire = !empty && q.deq_ready && !q.flush;
    occ      = wr_ptr - rd_ptr;
    head     = mem[rd_ptr[AW-1:0]];
  end

  // status outputs come from registered pointers only
  assign q.enq_ready   = !full;
  assign q.almost_full = occ >= AF;
  assign q.count       = occ;
  assign q.deq_valid   = !empty;
  assign q.deq_pc      = head[EW-1 -: 32];
  assign q.deq_instr   = head[EW-33 -: 32];
  assign q.deq_except  = head[18:0];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
    end

  // excepting fetches carry a NOP so stale Icache data never reaches ID
  always_ff @(posedge clk)
    if (enq_fire)
      mem[wr_ptr[AW-1:0]] <= {q.enq_pc, (|q.enq_except) ? 32'h0 : q.enq_instr, q.enq_except};

  a_no_enq_full:  assert property (@(posedge clk) disable iff (rst) !(enq_fire && full));
  a_no_deq_empty: assert property (@(posedge clk) disable iff (rst) !(deq_fire && empty));
  a_count_bound:  assert property (@(posedge clk) disable iff (rst) occ <= PW'(DEPTH));
endmodule

// File: tb/tb_if_inst_queue.sv
// tb_if_inst_queue: directed self-checking bench for the fetch queue
module tb_if_inst_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total = 0;

  if_inst_queue_if #(.DEPTH(8)) q ();

  if_inst_queue #(.DEPTH(8), .AF_LEVEL(6)) dut (
    .clk(clk),
    .rst(rst),
    .q  (q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [18:0] ex, input logic rdy);
    q.enq_valid  = v;
    q.enq_pc     = pc;
    q.enq_instr  = ins;
    q.enq_except = ex;
    q.deq_ready  = rdy;
  endtask

  initial begin
    q.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 19'h0, 1'b0);
    tick();
    chk("rst_count", 32'(q.count), 0);
    chk("rst_deq_valid", 32'(q.deq_valid), 0);
    chk("rst_enq_ready", 32'(q.enq_ready), 1);
    chk("rst_af", 32'(q.almost_full), 0);
    rst = 1'b0;
    tick();

    // three pushes held, then popped in order
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hBFC00000 + 32'(4 * i), 32'h24020001 + 32'(i), 19'h0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 19'h0, 1'b0);
    chk("t1_count", 32'(q.count), 3);
    chk("t1_head_pc", q.deq_pc, 32'hBFC00000);
    chk("t1_head_instr", q.deq_instr, 32'h24020001);
    q.deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop_pc", q.deq_pc, 32'hBFC00000 + 32'(4 * i));
      chk("t1_pop_instr", q.deq_instr, 32'h24020001 + 32'(i));
      tick();
    end
    q.deq_ready = 1'b0;
    chk("t1_empty_count", 32'(q.count), 0);
    chk("t1_empty_valid", 32'(q.deq_valid), 0);

    // fill to full, almost_full threshold, blocked ninth push
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 32'h100 + 32'(i), 19'h0, 1'b0);
      tick();
      if (i == 4) chk("t2_af_at5", 32'(q.almost_full), 0);
      if (i == 5) chk("t2_af_at6", 32'(q.almost_full), 1);
    end
    chk("t2_full_count", 32'(q.count), 8);
    chk("t2_full_ready", 32'(q.enq_ready), 0);
    chk("t2_full_af", 32'(q.almost_full), 1);
    drive(1'b1, 32'h1020, 32'h108, 19'h0, 1'b1);
    tick();
    chk("t2_ninth_count", 32'(q.count), 7);
    drive(1'b0, 32'h0, 32'h0, 19'h0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      chk("t2_drain_pc", q.deq_pc, 32'h1004 + 32'(4 * k));
      tick();
    end
    chk("t2_drained", 32'(q.count), 0);

    // streaming across pointer wrap
    drive(1'b1, 32'h2000, 32'h0, 19'h0, 1'b0);
    tick();
    for (int i = 1; i < 30; i++) begin
      drive(1'b1, 32'h2000 + 32'(4 * i), 32'h0, 19'h0, 1'b1);
      chk("t3_stream_pc", q.deq_pc, 32'h2000 + 32'(4 * (i - 1)));
      tick();
      chk("t3_stream_count", 32'(q.count), 1);
    end
    drive(1'b0, 32'h0, 32'h0, 19'h0, 1'b1);
    chk("t3_last_pc", q.deq_pc, 32'h2000 + 32'(4 * 29));
    tick();
    chk("t3_end_count", 32'(q.count), 0);

    // flush beats same-cycle enqueue and dequeue
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i), 32'h0, 19'h0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h3100, 32'h0, 19'h0, 1'b1);
    q.flush = 1'b1;
    chk("t4_preflush_count", 32'(q.count), 5);
    chk("t4_preflush_pc", q.deq_pc, 32'h3000);
    tick();
    q.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 19'h0, 1'b0);
    chk("t4_flush_count", 32'(q.count), 0);
    chk("t4_flush_valid", 32'(q.deq_valid), 0);
    chk("t4_flush_ready", 32'(q.enq_ready), 1);
    drive(1'b1, 32'h80000180, 32'h11111111, 19'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 19'h0, 1'b0);
    chk("t4_head_pc", q.deq_pc, 32'h80000180);
    chk("t4_head_count", 32'(q.count), 1);
    q.deq_ready = 1'b1;
    tick();
    q.deq_ready = 1'b0;

    // excepting word becomes NOP, normal word keeps its instruction
    drive(1'b1, 32'h4000, 32'hDEADBEEF, 19'h00100, 1'b0);
    tick();
    drive(1'b1, 32'h4004, 32'h12345678, 19'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 19'h0, 1'b0);
    chk("t5_exc_vec", 32'(q.deq_except), 32'h00100);
    chk("t5_exc_instr", q.deq_instr, 32'h0);
    chk("t5_exc_pc", q.deq_pc, 32'h4000);
    q.deq_ready = 1'b1;
    tick();
    chk("t5_next_instr", q.deq_instr, 32'h12345678);
    chk("t5_next_vec", 32'(q.deq_except), 0);
    tick();
    q.deq_ready = 1'b0;
    chk("t5_empty", 32'(q.count), 0);

    // asynchronous reset between edges
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h5000 + 32'(4 * i), 32'h0, 19'h0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 19'h0, 1'b0);
    chk("t6_held", 32'(q.count), 4);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_count", 32'(q.count), 0);
    chk("t6_async_valid", 32'(q.deq_valid), 0);
    chk("t6_async_ready", 32'(q.enq_ready), 1);
    #1 rst = 1'b0;
    drive(1'b1, 32'h6000, 32'h0, 19'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 19'h0, 1'b0);
    chk("t6_resume_count", 32'(q.count), 1);
    chk("t6_resume_pc", q.deq_pc, 32'h6000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
